// File: rtl/ahb_lite_master_if.sv
// Command stream and AHB-Lite bus bundle for ahb_lite_master.
// master modport is the initiator view; slave modport is the bus/user side.
interface ahb_lite_master_if #(
    parameter int ADDR_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [1:0]        cmd_size;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [31:0]       HWDATA;
    logic [31:0]       HRDATA;
    logic              HREADY;
    logic              HRESP;

    modport master (
        input  cmd_valid, cmd_write, cmd_size,
        input  cmd_addr, cmd_wdata,
        input  HRDATA, HREADY, HRESP,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output HADDR, HTRANS, HWRITE, HSIZE, HWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_size,
        output cmd_addr, cmd_wdata,
        output HRDATA, HREADY, HRESP,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA
    );
endinterface

// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: valid/ready commands to pipelined NONSEQ transfers.
// AHB_MASTER_TIMEOUT_EN adds a sticky timeout output and TO_W wait counter.
module ahb_lite_master #(
    parameter int ADDR_W = 32
`ifdef AHB_MASTER_TIMEOUT_EN
    , parameter int TO_W = 8
`endif
) (
    input  logic HCLK,
    input  logic HRESETn,
`ifdef AHB_MASTER_TIMEOUT_EN
    output logic timeout,
`endif
    ahb_lite_master_if.master bus
);
    typedef enum logic [1:0] {
        C_IDLE,
        C_WAIT,
        C_RSP
    } cst_t;

    cst_t cst, cst_nx;

    logic              a_valid;
    logic              a_write;
    logic [2:0]        a_size;
    logic [ADDR_W-1:0] a_addr;
    logic [31:0]       a_wdata;
    logic              d_valid;
    logic              d_write;
    logic [2:0]        d_size;
    logic [1:0]        d_lo;
    logic [31:0]       d_wdata;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [31:0]       rsp_rdata_q;

    logic              cancel_cycle;
    logic              accept;
    logic              cancel_rsp;
    logic [2:0]        c_hsize;
    logic [ADDR_W-1:0] c_addr;
    logic [31:0]       c_wdata;
    logic [31:0]       rd_sh;
    logic [31:0]       rd_lane;

    // First ERROR cycle of a two-cycle response kills the queued A command
    assign cancel_cycle = d_valid & bus.HRESP & ~bus.HREADY;
    assign bus.cmd_ready = bus.HREADY & ~cancel_cycle;
    assign accept = bus.cmd_valid & bus.cmd_ready;
    assign cancel_rsp = (cst == C_RSP);

    assign bus.HTRANS = {a_valid, 1'b0};
    assign bus.HADDR = a_addr;
    assign bus.HWRITE = a_write;
    assign bus.HSIZE = a_size;
    assign bus.HWDATA = d_wdata;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    always_comb begin
        c_hsize = 3'd2;
        c_addr = bus.cmd_addr;
        c_wdata = bus.cmd_wdata;
        unique case (1'b1)
            (bus.cmd_size == 2'd0): begin
                c_hsize = 3'd0;
                c_wdata = {4{bus.cmd_wdata[7:0]}};
            end
            (bus.cmd_size == 2'd1): begin
                c_hsize = 3'd1;
                c_addr[0] = 1'b0;
                c_wdata = {2{bus.cmd_wdata[15:0]}};
            end
            default: c_addr[1:0] = 2'b00;
        endcase
    end

    always_comb begin
        rd_lane = '0;
        rd_sh = bus.HRDATA >> {d_lo, 3'b000};
        if (!d_write) begin
            unique case (1'b1)
                (d_size == 3'd0): rd_lane = {24'h0, rd_sh[7:0]};
                (d_size == 3'd1): rd_lane = {16'h0, rd_sh[15:0]};
                default:          rd_lane = bus.HRDATA;
            endcase
        end
    end

    always_comb begin
        cst_nx = cst;
        unique case (cst)
            C_IDLE: if (cancel_cycle && a_valid) cst_nx = C_WAIT;
            C_WAIT: if (bus.HREADY) cst_nx = C_RSP;
            C_RSP:  cst_nx = C_IDLE;
            default: cst_nx = C_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            cst <= C_IDLE;
            a_valid <= 1'b0;
            a_write <= 1'b0;
            a_size <= '0;
            a_addr <= '0;
            a_wdata <= '0;
            d_valid <= 1'b0;
            d_write <= 1'b0;
            d_size <= '0;
            d_lo <= '0;
            d_wdata <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            cst <= cst_nx;
            rsp_valid_q <= 1'b0;
            if (bus.HREADY) begin
                d_valid <= a_valid;
                d_write <= a_write;
                d_size <= a_size;
                d_lo <= a_addr[1:0];
                d_wdata <= a_wdata;
                a_valid <= accept;
                if (accept) begin
                    a_write <= bus.cmd_write;
                    a_size <= c_hsize;
                    a_addr <= c_addr;
                    a_wdata <= c_wdata;
                end
            end else if (cancel_cycle) begin
                a_valid <= 1'b0;
            end
            if (bus.HREADY && d_valid) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q <= bus.HRESP;
                rsp_rdata_q <= rd_lane;
            end else if (cancel_rsp) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q <= 1'b1;
                rsp_rdata_q <= '0;
            end
        end
    end

`ifdef AHB_MASTER_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_nx;
    logic            to_q;

    assign to_nx = to_cnt + TO_W'(1);
    assign timeout = to_q;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            to_cnt <= '0;
            to_q <= 1'b0;
        end else if (bus.HREADY) begin
            to_cnt <= '0;
        end else if (d_valid && !(&to_cnt)) begin
            to_cnt <= to_nx;
            if (&to_nx) to_q <= 1'b1;
        end
    end
`else
`endif
endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master against a small SRAM slave model
// with injectable wait states and two-cycle ERROR responses.
module tb_ahb_lite_master;
    logic HCLK;
    logic rst_n;
    logic hready = 1'b1;
    logic hresp = 1'b0;
`ifdef AHB_MASTER_TIMEOUT_EN
    logic timeout;
`endif

    ahb_lite_master_if #(.ADDR_W(32)) ifc ();

    ahb_lite_master #(.ADDR_W(32)) dut (
        .HCLK    (HCLK),
        .HRESETn (rst_n),
`ifdef AHB_MASTER_TIMEOUT_EN
        .timeout (timeout),
`endif
        .bus     (ifc.master)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge HCLK) cyc <= cyc + 1;

    // SRAM slave model
    logic [31:0] mem [0:1023];
    logic        dph_valid = 1'b0;
    logic        dph_write = 1'b0;
    logic [2:0]  dph_size = '0;
    logic [31:0] dph_addr = '0;
    logic [31:0] last_addr = '0;
    int          xfers = 0;

    assign ifc.HREADY = hready;
    assign ifc.HRESP = hresp;
    assign ifc.HRDATA = mem[dph_addr[11:2]];

    always @(posedge HCLK) begin
        if (!rst_n) begin
            dph_valid <= 1'b0;
        end else if (hready) begin
            if (dph_valid && dph_write && !hresp) begin
                case (dph_size)
                    3'd0: mem[dph_addr[11:2]][8*dph_addr[1:0] +: 8]
                            <= ifc.HWDATA[8*dph_addr[1:0] +: 8];
                    3'd1: mem[dph_addr[11:2]][16*dph_addr[1] +: 16]
                            <= ifc.HWDATA[16*dph_addr[1] +: 16];
                    default: mem[dph_addr[11:2]] <= ifc.HWDATA;
                endcase
            end
            dph_valid <= (ifc.HTRANS == 2'b10);
            dph_write <= ifc.HWRITE;
            dph_size <= ifc.HSIZE;
            dph_addr <= ifc.HADDR;
            if (ifc.HTRANS == 2'b10) begin
                xfers <= xfers + 1;
                last_addr <= ifc.HADDR;
            end
        end
    end

    // Wait/error stub: requests are cumulative counts set by the stimulus
    int wait_cfg = 0;
    int wait_used = 0;
    int err_cfg = 0;
    int err_used = 0;
    int err_ph = 0;

    always @(posedge HCLK) begin
        #2;
        hready = 1'b1;
        hresp = 1'b0;
        if (!rst_n) begin
            wait_used = wait_cfg;
            err_used = err_cfg;
            err_ph = 0;
        end else if (err_ph == 1) begin
            hresp = 1'b1;
            err_ph = 0;
        end else if (dph_valid && err_used < err_cfg) begin
            hready = 1'b0;
            hresp = 1'b1;
            err_used++;
            err_ph = 1;
        end else if (dph_valid && wait_used < wait_cfg) begin
            hready = 1'b0;
            wait_used++;
        end
    end

    // Response log and stall monitor
    int          n_rsp = 0;
    logic [31:0] r_data [64];
    logic        r_err [64];
    int          r_t [64];
    logic [31:0] last_hwdata = '0;
    int          stall_n = 0;
    int          stall_bad = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_a = '0;
    logic [31:0] prev_w = '0;

    always @(negedge HCLK) begin
        if (ifc.rsp_valid && n_rsp < 64) begin
            r_data[n_rsp] = ifc.rsp_rdata;
            r_err[n_rsp] = ifc.rsp_err;
            r_t[n_rsp] = cyc;
            n_rsp++;
        end
        if (dph_valid && dph_write) last_hwdata = ifc.HWDATA;
        if (rst_n && !hready && !hresp) begin
            stall_n++;
            if (ifc.cmd_ready) stall_bad++;
            if (prev_stall && (ifc.HADDR !== prev_a ||
                               ifc.HWDATA !== prev_w))
                stall_bad++;
        end
        prev_stall = rst_n && !hready && !hresp;
        prev_a = ifc.HADDR;
        prev_w = ifc.HWDATA;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: sim time expired, run did not finish");
        $fatal(1, "watchdog");
    end

    int n_acc = 0;
    int acc [64];
    int n_exp = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge HCLK);
        #1;
    endtask

    task automatic send(input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
        logic ok;
        ok = 1'b0;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_write = w;
        ifc.cmd_size = sz;
        ifc.cmd_addr = a;
        ifc.cmd_wdata = wd;
        for (int i = 0; i < 40 && !ok; i++) begin
            ok = ifc.cmd_ready;
            step();
        end
        chk("accept", {31'h0, ok}, 32'h1);
        if (n_acc < 64) acc[n_acc] = cyc;
        n_acc++;
    endtask

    task automatic idle();
        ifc.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int bound);
        for (int i = 0; i < bound && n_rsp < n_exp; i++) step();
        chk("rsp_count", n_rsp, n_exp);
    endtask

    task automatic single(input string tag, input logic w,
                          input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] ed);
        send(w, sz, a, wd);
        idle();
        n_exp++;
        wait_rsp(60);
        chk(tag, r_data[n_exp-1], ed);
        chk({tag, "_err"}, {31'h0, r_err[n_exp-1]}, 32'h0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_htrans"}, {30'h0, ifc.HTRANS}, 32'h0);
        chk({tag, "_haddr"}, ifc.HADDR, 32'h0);
        chk({tag, "_hwrite"}, {31'h0, ifc.HWRITE}, 32'h0);
        chk({tag, "_hsize"}, {29'h0, ifc.HSIZE}, 32'h0);
        chk({tag, "_hwdata"}, ifc.HWDATA, 32'h0);
        chk({tag, "_rsp_valid"}, {31'h0, ifc.rsp_valid}, 32'h0);
        chk({tag, "_rsp_rdata"}, ifc.rsp_rdata, 32'h0);
        chk({tag, "_rsp_err"}, {31'h0, ifc.rsp_err}, 32'h0);
    endtask

    initial begin
        int k;
        int ka;
        int x0;
        int nr;
        rst_n = 1'b0;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_write = 1'b0;
        ifc.cmd_size = 2'd0;
        ifc.cmd_addr = '0;
        ifc.cmd_wdata = '0;
        repeat (3) step();
        chk_reset("reset");
        rst_n = 1'b1;
        step();

        // word write then read back, 2-cycle latency
        single("t1_wr", 1'b1, 2'd2, 32'h0, 32'h44332211, 32'h0);
        chk("t1_lat", r_t[0] - acc[0], 32'd2);
        single("t1_rd", 1'b0, 2'd2, 32'h0, 32'h0, 32'h44332211);

        // sub-word lanes and alignment
        single("t2_half", 1'b0, 2'd1, 32'h2, 32'h0, 32'h00004433);
        single("t2_byte", 1'b0, 2'd0, 32'h1, 32'h0, 32'h00000022);
        single("t2_wrb", 1'b1, 2'd0, 32'h3, 32'h000000AB, 32'h0);
        chk("t2_hwdata", last_hwdata, 32'hABABABAB);
        single("t2_word", 1'b0, 2'd2, 32'h0, 32'h0, 32'hAB332211);
        single("t2_unal", 1'b0, 2'd1, 32'h3, 32'h0, 32'h0000AB33);
        chk("t2_haddr", last_addr, 32'h2);

        // back-to-back stream
        k = n_exp;
        ka = n_acc;
        x0 = xfers;
        send(1'b1, 2'd2, 32'h10, 32'h11111111);
        send(1'b1, 2'd2, 32'h14, 32'h22222222);
        send(1'b0, 2'd2, 32'h10, 32'h0);
        send(1'b0, 2'd2, 32'h14, 32'h0);
        idle();
        n_exp += 4;
        wait_rsp(60);
        chk("t3_acc_span", acc[ka+3] - acc[ka], 32'd3);
        chk("t3_rsp_span", r_t[k+3] - r_t[k], 32'd3);
        chk("t3_xfers", xfers - x0, 32'd4);
        chk("t3_rd0", r_data[k+2], 32'h11111111);
        chk("t3_rd1", r_data[k+3], 32'h22222222);

        // three wait states on a read with a write queued behind it
        k = n_exp;
        ka = n_acc;
        x0 = stall_n;
        nr = stall_bad;
        wait_cfg += 3;
        send(1'b0, 2'd2, 32'h14, 32'hCAFEF00D);
        send(1'b1, 2'd2, 32'h18, 32'h33333333);
        idle();
        n_exp += 2;
        wait_rsp(60);
        chk("t4_rd", r_data[k], 32'h22222222);
        chk("t4_lat", r_t[k] - acc[ka], 32'd5);
        chk("t4_stalls", stall_n - x0, 32'd3);
        chk("t4_stable", stall_bad - nr, 32'd0);
        chk("t4_wr_err", {31'h0, r_err[k+1]}, 32'h0);

        // ERROR on a write with a read queued
        k = n_exp;
        x0 = xfers;
        err_cfg += 1;
        send(1'b1, 2'd2, 32'h20, 32'h55555555);
        send(1'b0, 2'd2, 32'h24, 32'h0);
        chk("t5_ready", {31'h0, ifc.cmd_ready}, 32'h0);
        idle();
        step();
        chk("t5_htrans", {30'h0, ifc.HTRANS}, 32'h0);
        n_exp += 2;
        wait_rsp(60);
        chk("t5_err0", {31'h0, r_err[k]}, 32'h1);
        chk("t5_err1", {31'h0, r_err[k+1]}, 32'h1);
        chk("t5_rdata1", r_data[k+1], 32'h0);
        chk("t5_order", r_t[k+1] - r_t[k], 32'd1);
        chk("t5_xfers", xfers - x0, 32'd1);

        // reset during a wait state drops the in-flight read
        wait_cfg += 5;
        send(1'b0, 2'd2, 32'h10, 32'h12345678);
        idle();
        step();
        nr = n_rsp;
        rst_n = 1'b0;
        step();
        chk_reset("t6");
        rst_n = 1'b1;
        repeat (6) step();
        chk("t6_dropped", n_rsp, nr);
        single("t6_rd", 1'b0, 2'd2, 32'h10, 32'h0, 32'h11111111);

`ifdef AHB_MASTER_TIMEOUT_EN
        chk("to_init", {31'h0, timeout}, 32'h0);
        wait_cfg += 260;
        send(1'b0, 2'd2, 32'h14, 32'h0);
        idle();
        repeat (200) step();
        chk("to_early", {31'h0, timeout}, 32'h0);
        n_exp++;
        wait_rsp(400);
        chk("to_set", {31'h0, timeout}, 32'h1);
        repeat (4) step();
        chk("to_sticky", {31'h0, timeout}, 32'h1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("to_reset", {31'h0, timeout}, 32'h0);
`endif

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
